carry_select_adder_pipe: RTL
============================

// Module: carry_select_adder_pipe
// PURPOSE
//   Parametrised two-stage pipelined carry-select adder with valid/ready handshake.
//   - Stage 1: per-block conditional sums for cin=0 and cin=1.
//   - Stage 2: carry-select mux chain resolves block carries; registers sum/cout.
//   Successor to the fixed 8-bit sum-select mux: a generalised, streamable adder
//   datapath for the arithmetic cluster.
// PARAMETERS
//   WIDTH  32  operand/sum width in bits; must be a multiple of BLK
//   BLK    8   bits per carry-select block; NBLK = WIDTH/BLK >= 1
// PORTS
//   clk        in   1      single clock, all state on rising edge
//   rst_n      in   1      synchronous active-low reset
//   in_valid   in   1      operands valid
//   in_ready   out  1      block accepts operands this cycle
//   a          in   WIDTH  operand A (unsigned)
//   b          in   WIDTH  operand B (unsigned)
//   cin        in   1      carry in
//   out_valid  out  1      sum/cout valid
//   out_ready  in   1      downstream accepts result
//   sum        out  WIDTH  (a+b+cin) mod 2^WIDTH
//   cout       out  1      carry out of MSB
// BEHAVIOUR
//   - Reset (rst_n=0 at clk edge): s1_v=0, s2_v=0 -> out_valid=0, sum=0, cout=0.
//     in_ready reads 1 during and after reset (both stages empty).
//   - Reset mid-operation flushes both stages; in-flight results are discarded.
//   - Transfers: input on in_valid&in_ready; output on out_valid&out_ready.
//   - en2 = !s2_v | out_ready; in_ready = en1 = !s1_v | en2 (combinational).
//   - Stage 1 (on en1): load s1_v<=in_valid. When in_valid, for each block k:
//     {c0[k],s0[k]} = a_k+b_k; {c1[k],s1[k]} = a_k+b_k+1; register cin.
//   - Stage 2 (on en2): load s2_v<=s1_v. When s1_v, resolve the carry chain:
//     sel[0]=cin; sum_k = sel[k] ? s1[k] : s0[k];
//     sel[k+1] = sel[k] ? c1[k] : c0[k]; cout = sel[NBLK].
//   - Latency: exactly 2 cycles accept->out_valid when out_ready held high.
//   - Throughput: 1 result/cycle when out_ready=1.
//   - Stall: out_valid&!out_ready holds sum/cout/out_valid stable.
//     s1 also holds if full; in_ready drops only when both stages full.
//   - Ordering: strict FIFO, no drop, no duplication.
//   - Wrap: all-ones + 0 + cin=1 -> sum=0, cout=1. NBLK=1 degenerates to a
//     registered ripple block with the same handshake.
//   - Width: block sums computed at BLK+1 bits; no sign extension anywhere.
// CONFIGURATION
//   Macro CSA_OVF_FLAG_EN:
//   - Defined: extra output port ovf (1 bit), registered alongside sum.
//     ovf = signed two's-complement overflow: carry into MSB xor cout,
//     computed from the MSB block's selected path; reset value 0.
//   - Undefined: port and logic absent; all other behaviour identical.
// STRUCTURE
//   - Package csa_pkg: function nblk(WIDTH,BLK); typedef csa_blk_t
//     {logic [BLK-1:0] s0, s1; logic c0, c1}; elaboration check WIDTH%BLK==0.
//   - Sub-module csel_block: one BLK-wide conditional-sum block
//     (a_k, b_k -> s0, s1, c0, c1), instantiated NBLK times by generate.
//   - Mux chain and pipeline registers live in the top module.
// TESTING
//   - Reset: rst_n=0 for 2 cycles with in_valid=1 -> out_valid=0, sum=0, in_ready=1.
//   - Basic: a=0x0000_00FF, b=0x0000_0001, cin=0 -> 2 cycles later sum=0x0000_0100, cout=0.
//   - Wrap: a=0xFFFF_FFFF, b=0, cin=1 -> sum=0, cout=1 (full carry ripple across 4 blocks).
//   - Backpressure: stream 6 ops, out_ready=0 for 3 cycles -> in_ready=0 once 2 held;
//     all 6 results in order, no loss; sum stable while stalled.
//   - Reset mid-flight: 2 ops accepted, rst_n=0 one cycle -> neither result ever appears.
//   - CSA_OVF_FLAG_EN: a=0x7FFF_FFFF, b=1 -> ovf=1, sum=0x8000_0000; a=b=0xFFFF_FFFF -> ovf=0.
//     Plus random 10k ops vs a+b+cin model at WIDTH/BLK = 32/8, 16/4, 8/8.

Source files
------------

// File: rtl/carry_select_adder_pipe_pkg.sv
// -----------------------------------------------------------------------------
// csa_pkg
// Shared helpers for the pipelined carry-select adder.
//   nblk(width, blk)   : number of carry-select blocks
//   cfg_ok(width, blk) : legal geometry (blk >= 1, width a non-zero multiple of blk)
// The per-block conditional-sum record (csa_blk_t) depends on BLK, so it is
// declared inside the top module where BLK is known.
// -----------------------------------------------------------------------------
package csa_pkg;

  function automatic int nblk(input int width, input int blk);
    return width / blk;
  endfunction

  function automatic bit cfg_ok(input int width, input int blk);
    return (blk >= 1) && (width >= blk) && ((width % blk) == 0);
  endfunction

endpackage

// File: rtl/carry_select_adder_pipe_if.sv
// -----------------------------------------------------------------------------
// carry_select_adder_pipe_if
// Operand/result stream bundle for carry_select_adder_pipe.
//   master : the environment (drives operands and out_ready)
//   slave  : the adder (drives in_ready and results)
// Handshake: a beat moves on a rising edge where valid & ready are both 1.
// A producer holding valid keeps its payload stable until the beat moves;
// ready may depend combinationally on downstream ready, never on valid.
// Optional macro CSA_OVF_FLAG_EN adds the ovf result bit.
// -----------------------------------------------------------------------------
interface carry_select_adder_pipe_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef CSA_OVF_FLAG_EN
  logic             ovf;
`endif

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout
`ifdef CSA_OVF_FLAG_EN
    , input ovf
`endif
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout
`ifdef CSA_OVF_FLAG_EN
    , output ovf
`endif
  );

endinterface

// File: rtl/carry_select_adder_pipe_csel_block.sv
// -----------------------------------------------------------------------------
// csel_block
// One BLK-wide conditional-sum block: computes both candidate results for
// carry-in 0 and carry-in 1 at BLK+1 bits (no sign extension).
//   a_i, b_i : block operand slices
//   s0_o/c0_o: sum/carry assuming carry-in 0
//   s1_o/c1_o: sum/carry assuming carry-in 1
// -----------------------------------------------------------------------------
module csel_block #(
  parameter int BLK = 8
) (
  input  logic [BLK-1:0] a_i,
  input  logic [BLK-1:0] b_i,
  output logic [BLK-1:0] s0_o,
  output logic [BLK-1:0] s1_o,
  output logic           c0_o,
  output logic           c1_o
);
  logic [BLK:0] r0;
  logic [BLK:0] r1;

  assign r0 = {1'b0, a_i} + {1'b0, b_i};
  // a+b+1 never exceeds 2^(BLK+1)-1, so r0+1 cannot wrap.
  assign r1 = r0 + {{BLK{1'b0}}, 1'b1};

  assign {c0_o, s0_o} = r0;
  assign {c1_o, s1_o} = r1;
endmodule

// File: rtl/carry_select_adder_pipe.sv
// -----------------------------------------------------------------------------
// carry_select_adder_pipe
// Two-stage pipelined carry-select adder with a valid/ready stream.
//   Stage 1: NBLK csel_block instances produce conditional sums; registered
//            together with cin.
//   Stage 2: carry-select mux chain picks each block's result; registers
//            sum/cout (and ovf when enabled).
// Ports:
//   clk    : rising-edge clock
//   rst_n  : synchronous active-low reset, flushes both stages
//   bus    : carry_select_adder_pipe_if.slave (a, b, cin in; sum, cout out)
// Parameters: WIDTH (multiple of BLK), BLK (bits per block).
// Optional macro CSA_OVF_FLAG_EN: adds registered signed-overflow flag ovf.
// -----------------------------------------------------------------------------
module carry_select_adder_pipe
  import csa_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int BLK   = 8
) (
  input logic                     clk,
  input logic                     rst_n,
  carry_select_adder_pipe_if.slave bus
);
  localparam int NBLK = nblk(WIDTH, BLK);

  if (!cfg_ok(WIDTH, BLK)) begin : g_cfg_err
    $error("carry_select_adder_pipe: WIDTH must be a non-zero multiple of BLK");
  end

  typedef struct packed {
    logic [BLK-1:0] s0;
    logic [BLK-1:0] s1;
    logic           c0;
    logic           c1;
  } csa_blk_t;

  // Pipeline control
  logic en1;
  logic en2;
  logic s1_v_q;
  logic s2_v_q;

  // Stage 1 datapath
  csa_blk_t blk_d [NBLK];
  csa_blk_t blk_q [NBLK];
  logic     cin_q;

  // Stage 2 datapath
  logic [NBLK:0]    sel;
  logic [WIDTH-1:0] sum_d;
  logic             cout_d;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;

  // A stage may load when it is empty or its content moves on this edge.
  assign en2 = !s2_v_q || bus.out_ready;
  assign en1 = !s1_v_q || en2;

  for (genvar k = 0; k < NBLK; k++) begin : g_blk
    logic [BLK-1:0] s0_w;
    logic [BLK-1:0] s1_w;
    logic           c0_w;
    logic           c1_w;

    csel_block #(.BLK(BLK)) u_csel (
      .a_i  (bus.a[k*BLK +: BLK]),
      .b_i  (bus.b[k*BLK +: BLK]),
      .s0_o (s0_w),
      .s1_o (s1_w),
      .c0_o (c0_w),
      .c1_o (c1_w)
    );

    assign blk_d[k] = '{s0: s0_w, s1: s1_w, c0: c0_w, c1: c1_w};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_v_q <= 1'b0;
      cin_q  <= 1'b0;
      for (int k = 0; k < NBLK; k++) blk_q[k] <= '0;
    end else if (en1) begin
      s1_v_q <= bus.in_valid;
      if (bus.in_valid) begin
        blk_q <= blk_d;
        cin_q <= bus.cin;
      end
    end
  end

  // Carry-select chain: each block's registered carry-in picks its candidate.
  always_comb begin
    sel    = '0;
    sum_d  = '0;
    sel[0] = cin_q;
    for (int k = 0; k < NBLK; k++) begin
      sum_d[k*BLK +: BLK] = sel[k] ? blk_q[k].s1 : blk_q[k].s0;
      sel[k+1]            = sel[k] ? blk_q[k].c1 : blk_q[k].c0;
    end
    cout_d = sel[NBLK];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_v_q <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else if (en2) begin
      s2_v_q <= s1_v_q;
      if (s1_v_q) begin
        sum_q  <= sum_d;
        cout_q <= cout_d;
      end
    end
  end

`ifdef CSA_OVF_FLAG_EN
  // Carry into the MSB is a^b^sum at that bit, so (cin_msb ^ cout) reduces
  // to: operands share a sign and the selected sum's sign differs from it.
  logic a_msb_q;
  logic b_msb_q;
  logic ovf_d;
  logic ovf_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
    end else if (en1 && bus.in_valid) begin
      a_msb_q <= bus.a[WIDTH-1];
      b_msb_q <= bus.b[WIDTH-1];
    end
  end

  assign ovf_d = (a_msb_q == b_msb_q) && (sum_d[WIDTH-1] != a_msb_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (en2 && s1_v_q) begin
      ovf_q <= ovf_d;
    end
  end

  assign bus.ovf = ovf_q;
`endif

  assign bus.in_ready  = en1;
  assign bus.out_valid = s2_v_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
endmodule
